soc_pm_sequencer: RTL and testbench

Command-driven sequencer that generates all pixel-matrix control waveforms (shift clock, mode select, gate, strobe, config latch) and moves shift data to and from the matrix. It is the parametrised successor of the software-toggled `soc_pm_ctrl` register. The CPU-side peripheral issues one command at a time over a valid/ready port, and the block executes it with programmable timing. It sits between the SoC bus peripheral and the pixel matrix and drives the matrix through a `soc_pm_ctrl.master` modport.

---
 rtl/soc_pm_seq_pkg.sv | 36 +++
 rtl/soc_pm_ctrl.sv | 19 +
 rtl/soc_pm_seq_divider.sv | 39 +++
 rtl/soc_pm_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_soc_pm_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_pm_seq_pkg.sv
// Shared types for the pixel-matrix sequencer: command opcodes and FSM states.
package soc_pm_seq_pkg;

    localparam int unsigned OP_WIDTH    = 3;
    localparam int unsigned STATE_WIDTH = 4;

    // Command opcodes as seen on cmd_op; unlisted encodings behave as NOP.
    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP       = 3'd0,
        OP_SHIFT     = 3'd1,
        OP_STROBE    = 3'd2,
        OP_GATE      = 3'd3,
        OP_WRITE_CFG = 3'd4
    } pm_op_e;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_IDLE     = 4'd0,
        S_SH_SETUP = 4'd1,
        S_SH_WAIT  = 4'd2,
        S_SH_LOW   = 4'd3,
        S_SH_HIGH  = 4'd4,
        S_SH_HOLD  = 4'd5,
        S_ST_HIGH  = 4'd6,
        S_ST_LOW   = 4'd7,
        S_GATE     = 4'd8,
        S_WCFG     = 4'd9,
        S_FINISH   = 4'd10
    } pm_seq_state_e;

    // shA is held for the whole shift transaction, setup through hold.
    function automatic logic is_shift_state(input pm_seq_state_e s);
        return (s == S_SH_SETUP) || (s == S_SH_WAIT) || (s == S_SH_LOW) ||
               (s == S_SH_HIGH) || (s == S_SH_HOLD);
    endfunction

endpackage

// File: rtl/soc_pm_ctrl.sv
// Pixel-matrix control lines; the sequencer drives them through the master modport.
//   clkSh     shift clock
//   shA/shB   shift mode selects (shB unused, tied low)
//   res       matrix reset (tied low)
//   gate      acquisition gate
//   strobe    test-pulse strobe
//   write_cfg configuration latch
interface soc_pm_ctrl;
    logic clkSh;
    logic shA;
    logic shB;
    logic res;
    logic gate;
    logic strobe;
    logic write_cfg;

    modport master (output clkSh, shA, shB, res, gate, strobe, write_cfg);
    modport slave  (input  clkSh, shA, shB, res, gate, strobe, write_cfg);
endinterface

// File: rtl/soc_pm_seq_divider.sv
// Half-period timer shared by every timed sequencer state.
//   clk, rst  clock, asynchronous active-high reset
//   load      restart the period with load_val (period = load_val + 1 cycles)
//   load_val  half-period minus one
//   tick      high in the last cycle of the current period
module soc_pm_seq_divider #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_val,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    // Count down to zero and park there until the next load.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/soc_pm_sequencer.sv
// Command-driven pixel-matrix sequencer: executes SHIFT / STROBE / GATE / WRITE_CFG
// commands with programmable half-period and generates the matrix control waveforms.
//   cmd_*            one-at-a-time command port (valid/ready)
//   tx_* / rx_*      shift-word streams to and from the matrix
//   busy, done       command progress / one-cycle completion pulse
//   pm_din, pm_dout  matrix column data
//   pm_ctrl          matrix control lines
module soc_pm_sequencer
    import soc_pm_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned DIV_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    input  logic [DIV_WIDTH-1:0]  cmd_div,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] pm_din,
    input  logic [DATA_WIDTH-1:0] pm_dout,
    soc_pm_ctrl.master            pm_ctrl
);

    pm_seq_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  clksh_q, clksh_d;
    logic                  sha_q, sha_d;
    logic                  gate_q, gate_d;
    logic                  strobe_q, strobe_d;
    logic                  wcfg_q, wcfg_d;

    logic                  div_load_c;
    logic [DIV_WIDTH-1:0]  div_val_c;
    logic                  tick;

    soc_pm_seq_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load_c),
        .load_val (div_val_c),
        .tick     (tick)
    );

    // Next state, latched command fields and data path.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        din_d      = din_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        div_load_c = 1'b0;
        div_val_c  = div_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cnt_d     = cmd_count;
                    div_d     = cmd_div;
                    // The divider loads on the accept edge, before div_q holds the new value.
                    div_val_c = cmd_div;
                    if (cmd_count == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        unique case (pm_op_e'(cmd_op))
                            OP_SHIFT: begin
                                state_d    = S_SH_SETUP;
                                div_load_c = 1'b1;
                            end
                            OP_STROBE: begin
                                state_d    = S_ST_HIGH;
                                div_load_c = 1'b1;
                            end
                            OP_GATE: begin
                                state_d = S_GATE;
                            end
                            OP_WRITE_CFG: begin
                                state_d    = S_WCFG;
                                div_load_c = 1'b1;
                            end
                            default: begin
                                state_d = S_FINISH;
                            end
                        endcase
                    end
                end
            end
            S_SH_SETUP: begin
                if (tick) begin
                    state_d = S_SH_WAIT;
                end
            end
            S_SH_WAIT: begin
                if (tx_valid) begin
                    state_d    = S_SH_LOW;
                    din_d      = tx_data;
                    div_load_c = 1'b1;
                end
            end
            S_SH_LOW: begin
                // Capture matrix output on the edge that raises clkSh.
                if (tick) begin
                    state_d    = S_SH_HIGH;
                    div_load_c = 1'b1;
                    rx_data_d  = pm_dout;
                    rx_valid_d = 1'b1;
                end
            end
            S_SH_HIGH: begin
                if (tick) begin
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d    = S_SH_HOLD;
                        div_load_c = 1'b1;
                    end else begin
                        state_d = S_SH_WAIT;
                        cnt_d   = cnt_q - CNT_WIDTH'(1);
                    end
                end
            end
            S_SH_HOLD: begin
                if (tick) begin
                    state_d = S_FINISH;
                end
            end
            S_ST_HIGH: begin
                if (tick) begin
                    state_d    = S_ST_LOW;
                    div_load_c = 1'b1;
                end
            end
            S_ST_LOW: begin
                if (tick) begin
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d    = S_ST_HIGH;
                        cnt_d      = cnt_q - CNT_WIDTH'(1);
                        div_load_c = 1'b1;
                    end
                end
            end
            S_GATE: begin
                // Gate runs on raw clk cycles, one per count.
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_WCFG: begin
                if (tick) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the next state so they change with the state.
    always_comb begin
        sha_d    = is_shift_state(state_d);
        clksh_d  = (state_d == S_SH_HIGH);
        strobe_d = (state_d == S_ST_HIGH);
        gate_d   = (state_d == S_GATE);
        wcfg_d   = (state_d == S_WCFG);
        done_d   = (state_d == S_FINISH);
        busy_d   = (state_d != S_IDLE) && (state_d != S_FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            din_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clksh_q    <= 1'b0;
            sha_q      <= 1'b0;
            gate_q     <= 1'b0;
            strobe_q   <= 1'b0;
            wcfg_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            din_q      <= din_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            clksh_q    <= clksh_d;
            sha_q      <= sha_d;
            gate_q     <= gate_d;
            strobe_q   <= strobe_d;
            wcfg_q     <= wcfg_d;
        end
    end

    // Handshake readies come straight from the state; cmd_ready stays low while in reset.
    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign tx_ready  = (state_q == S_SH_WAIT);

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pm_din   = din_q;

    assign pm_ctrl.clkSh     = clksh_q;
    assign pm_ctrl.shA       = sha_q;
    assign pm_ctrl.shB       = 1'b0;
    assign pm_ctrl.res       = 1'b0;
    assign pm_ctrl.gate      = gate_q;
    assign pm_ctrl.strobe    = strobe_q;
    assign pm_ctrl.write_cfg = wcfg_q;

endmodule

// File: tb/tb_soc_pm_sequencer.sv
// Bench for soc_pm_sequencer: builds the expected per-cycle waveform of each command
// from its timing rules, then checks every cycle of the DUT against it.
module tb_soc_pm_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned VW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_count;
    logic [VW-1:0] cmd_div;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          done;
    logic [DW-1:0] pm_din;
    logic [DW-1:0] pm_dout = '0;

    soc_pm_ctrl pm_if ();

    soc_pm_sequencer #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .DIV_WIDTH  (VW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_div   (cmd_div),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .done      (done),
        .pm_din    (pm_din),
        .pm_dout   (pm_dout),
        .pm_ctrl   (pm_if)
    );

    always #5 clk = ~clk;

    // One expected cycle: outputs plus the stimulus to apply in that cycle.
    typedef struct {
        logic          clksh, sha, strobe, gate, wcfg;
        logic          busy, done, cready, tready, rxv;
        logic          tv, cv;
        logic [DW-1:0] din, td;
        int            idx;
    } ent_t;

    ent_t          exp_q[$];
    ent_t          tr[$];
    logic [DW-1:0] w[0:3];
    logic [DW-1:0] cur_din = '0;
    logic [DW-1:0] exp_rx  = '0;
    logic [DW-1:0] prev_dout = '0;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_done  = 0;
    int            done_off, clksh_rises, strobe_rises, gate_hi, wcfg_hi, rxv_cnt;
    logic          prev_clksh = 1'b0;
    logic          prev_strobe = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Matrix output changes every cycle so each capture is distinguishable.
    always @(posedge clk) begin
        #1;
        pm_dout = DW'($urandom);
    end

    // Per-cycle compare against the expected waveform.
    always @(negedge clk) begin
        ent_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.idx == 0) begin
                done_off = -1; clksh_rises = 0; strobe_rises = 0;
                gate_hi = 0; wcfg_hi = 0; rxv_cnt = 0;
            end
            if (e.rxv) exp_rx = prev_dout;
            chk($sformatf("ctrl[%0d]", e.idx),
                {60'd0, pm_if.clkSh, pm_if.shA, pm_if.shB, pm_if.res},
                {60'd0, e.clksh, e.sha, 2'b00});
            chk($sformatf("gsw[%0d]", e.idx),
                {pm_if.gate, pm_if.strobe, pm_if.write_cfg},
                {e.gate, e.strobe, e.wcfg});
            chk($sformatf("status[%0d]", e.idx),
                {busy, done, cmd_ready, tx_ready, rx_valid},
                {e.busy, e.done, e.cready, e.tready, e.rxv});
            chk($sformatf("pm_din[%0d]", e.idx), pm_din, e.din);
            chk($sformatf("rx_data[%0d]", e.idx), rx_data, exp_rx);
            if (pm_if.clkSh && !prev_clksh) clksh_rises++;
            if (pm_if.strobe && !prev_strobe) strobe_rises++;
            if (pm_if.gate) gate_hi++;
            if (pm_if.write_cfg) wcfg_hi++;
            if (rx_valid) rxv_cnt++;
            if (done) done_off = e.idx;
        end
        prev_clksh  = pm_if.clkSh;
        prev_strobe = pm_if.strobe;
        if (done === 1'b1) n_done++;
        prev_dout = pm_dout;
    end

    function automatic ent_t mk();
        ent_t e = '{default: 0};
        e.din = cur_din;
        e.td  = 16'hDEAD;
        e.tv  = 1'b1;
        e.idx = tr.size();
        return e;
    endfunction

    task automatic add(input logic sha, input logic clksh, input logic strobe, input logic gate,
                       input logic wcfg, input logic tready, input logic rxv, input logic tv,
                       input logic [DW-1:0] td);
        ent_t e = mk();
        e.busy = 1'b1; e.sha = sha; e.clksh = clksh; e.strobe = strobe; e.gate = gate;
        e.wcfg = wcfg; e.tready = tready; e.rxv = rxv; e.tv = tv; e.td = td;
        tr.push_back(e);
    endtask

    // Expected waveform of one command, derived from its timing rules.
    task automatic build(input int op, input int cnt, input int div, input int stall_bit,
                         input int stall_len, input bit junk);
        int   h = div + 1;
        ent_t e;
        tr.delete();
        e = mk(); e.cready = 1'b1; e.tv = 1'b0; tr.push_back(e);
        if (cnt != 0) begin
            case (op)
                1: begin
                    repeat (h) add(1, 0, 0, 0, 0, 0, 0, 1, 16'hDEAD);
                    for (int b = 0; b < cnt; b++) begin
                        if (b == stall_bit) repeat (stall_len) add(1, 0, 0, 0, 0, 1, 0, 0, w[b]);
                        add(1, 0, 0, 0, 0, 1, 0, 1, w[b]);
                        cur_din = w[b];
                        repeat (h) add(1, 0, 0, 0, 0, 0, 0, 1, 16'hDEAD);
                        for (int i = 0; i < h; i++) add(1, 1, 0, 0, 0, 0, i == 0, 1, 16'hDEAD);
                    end
                    repeat (h) add(1, 0, 0, 0, 0, 0, 0, 1, 16'hDEAD);
                end
                2: for (int p = 0; p < cnt; p++) begin
                    repeat (h) add(0, 0, 1, 0, 0, 0, 0, 1, 16'hDEAD);
                    repeat (h) add(0, 0, 0, 0, 0, 0, 0, 1, 16'hDEAD);
                end
                3: repeat (cnt) add(0, 0, 0, 1, 0, 0, 0, 1, 16'hDEAD);
                4: repeat (h) add(0, 0, 0, 0, 1, 0, 0, 1, 16'hDEAD);
                default: ;
            endcase
        end
        e = mk(); e.done = 1'b1; tr.push_back(e);
        e = mk(); e.cready = 1'b1; e.tv = 1'b0; tr.push_back(e);
        if (junk) for (int i = 1; i <= 3 && i < tr.size() - 2; i++) tr[i].cv = 1'b1;
    endtask

    // Offer a command and follow its waveform; abort_at > 0 stops driving early.
    task automatic run_cmd(input int op, input int cnt, input int div, input int stall_bit,
                           input int stall_len, input bit junk, input int abort_at);
        build(op, cnt, div, stall_bit, stall_len, junk);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 3'(op); cmd_count = CW'(cnt); cmd_div = VW'(div);
        tx_valid = tr[0].tv; tx_data = tr[0].td;
        foreach (tr[i]) exp_q.push_back(tr[i]);
        for (int k = 1; k < tr.size() && (abort_at == 0 || k < abort_at); k++) begin
            @(posedge clk); #1;
            cmd_valid = tr[k].cv;
            cmd_op    = 3'd2;
            cmd_count = CW'($urandom);
            cmd_div   = VW'($urandom);
            tx_valid  = tr[k].tv;
            tx_data   = tr[k].td;
        end
        if (abort_at == 0) begin
            @(negedge clk); #1;
            chk("drain", 64'(exp_q.size()), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int dn;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_count = '0; cmd_div = '0;
        tx_data = '0; tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {pm_if.clkSh, pm_if.shA, pm_if.shB, pm_if.res, pm_if.gate,
                         pm_if.strobe, pm_if.write_cfg}, 64'd0);
        chk("rst_status", {busy, done, cmd_ready, tx_ready, rx_valid}, 64'd0);
        chk("rst_data", {pm_din, rx_data}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 64'd1);

        // SHIFT 3 bits, H=2, tx_valid always high.
        w[0] = 16'hA5A5; w[1] = 16'h0001; w[2] = 16'hFFFF;
        run_cmd(1, 3, 1, -1, 0, 1'b0, 0);
        chk("sh_done_off", 64'(done_off), 64'd20);
        chk("sh_pulses", 64'(clksh_rises), 64'd3);
        chk("sh_rxv", 64'(rxv_cnt), 64'd3);
        chk("sh_last_din", pm_din, 64'hFFFF);

        // SHIFT with a 10-cycle tx stall before the second bit.
        w[0] = 16'h1234; w[1] = 16'h8000; w[2] = 16'h0F0F;
        run_cmd(1, 3, 1, 1, 10, 1'b0, 0);
        chk("stall_done_off", 64'(done_off), 64'd30);
        chk("stall_pulses", 64'(clksh_rises), 64'd3);

        // STROBE 4 pulses at H=1.
        run_cmd(2, 4, 0, -1, 0, 1'b0, 0);
        chk("st_done_off", 64'(done_off), 64'd9);
        chk("st_pulses", 64'(strobe_rises), 64'd4);

        // GATE 5 with commands offered while busy.
        run_cmd(3, 5, 7, -1, 0, 1'b1, 0);
        chk("gate_hi", 64'(gate_hi), 64'd5);
        chk("gate_done_off", 64'(done_off), 64'd6);

        // WRITE_CFG at H=3.
        run_cmd(4, 1, 2, -1, 0, 1'b0, 0);
        chk("wcfg_hi", 64'(wcfg_hi), 64'd3);
        chk("wcfg_done_off", 64'(done_off), 64'd4);

        // STROBE 2 pulses at H=3.
        run_cmd(2, 2, 2, -1, 0, 1'b0, 0);
        chk("st3_done_off", 64'(done_off), 64'd13);

        // Zero-count SHIFT and undefined opcode finish immediately.
        run_cmd(1, 0, 3, -1, 0, 1'b0, 0);
        chk("zero_done_off", 64'(done_off), 64'd1);
        run_cmd(7, 5, 3, -1, 0, 1'b0, 0);
        chk("op7_done_off", 64'(done_off), 64'd1);
        chk("op7_pulses", 64'(clksh_rises + strobe_rises + gate_hi + wcfg_hi), 64'd0);

        // Reset in the middle of a SHIFT.
        w[0] = 16'h5A5A; w[1] = 16'hC3C3; w[2] = 16'h7E7E;
        run_cmd(1, 3, 3, -1, 0, 1'b0, 8);
        dn = n_done;
        @(posedge clk); #1;
        exp_q.delete();
        rst = 1'b1;
        cur_din = '0; exp_rx = '0;
        #1;
        chk("arst_ctrl", {pm_if.clkSh, pm_if.shA, pm_if.shB, pm_if.res, pm_if.gate,
                          pm_if.strobe, pm_if.write_cfg}, 64'd0);
        chk("arst_status", {busy, done, cmd_ready, tx_ready, rx_valid}, 64'd0);
        chk("arst_din", pm_din, 64'd0);
        tx_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_no_done", 64'(n_done), 64'(dn));
        chk("arst_ready", {cmd_ready, busy}, 64'b10);

        // A normal command still works after the aborted one.
        w[0] = 16'h0F0F;
        run_cmd(1, 1, 0, -1, 0, 1'b0, 0);
        chk("post_done_off", 64'(done_off), 64'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
